// File: rtl/alarm_trigger_fsm_pkg.sv
// Shared types and constants for the alarm trigger block: state encodings,
// BCD digit width and the timer width helper.
package alarm_trigger_fsm_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    // A one-second timer for N seconds needs to hold 0..N-1; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_trigger_fsm_if.sv
// Bundle of time/alarm digits, user controls and buzzer/status outputs
// between the counters, buttons and the alarm trigger FSM.
interface alarm_trigger_fsm_if;

    logic sec_tick;
    logic alarm_en;
    logic snooze;
    logic dismiss;

    logic [alarm_trigger_fsm_pkg::BCD_W-1:0] t_hh, t_hl, t_mh, t_ml, t_sh, t_sl;
    logic [alarm_trigger_fsm_pkg::BCD_W-1:0] a_hh, a_hl, a_mh, a_ml, a_sh, a_sl;

    logic       buzz;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_cnt;

    modport master (
        output sec_tick, alarm_en, snooze, dismiss,
        output t_hh, t_hl, t_mh, t_ml, t_sh, t_sl,
        output a_hh, a_hl, a_mh, a_ml, a_sh, a_sl,
        input  buzz, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  sec_tick, alarm_en, snooze, dismiss,
        input  t_hh, t_hl, t_mh, t_ml, t_sh, t_sl,
        input  a_hh, a_hl, a_mh, a_ml, a_sh, a_sl,
        output buzz, ringing, snoozing, snooze_cnt
    );

endinterface

// File: rtl/alarm_trigger_fsm_sec_timer.sv
// Seconds timer: counts qualified ticks while not cleared and flags the tick
// that completes N seconds.
module alarm_sec_timer
    import alarm_trigger_fsm_pkg::*;
#(
    parameter int N = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign done = tick & (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_trigger_fsm.sv
// Alarm trigger: detects time==alarm, rings, snoozes, dismisses and times out.
// Build option ALARM_BEEP_EN gates the buzzer 1 s on / 1 s off while ringing.
module alarm_trigger_fsm
    import alarm_trigger_fsm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                clk,
    input  logic                reset,
    alarm_trigger_fsm_if.slave  bus
);

`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    state_t     state;
    logic       match;
    logic       match_q;
    logic       match_rise;
    logic       abort;
    logic       take_snooze;
    logic       ring_tick;
    logic       snz_tick;
    logic       ring_done;
    logic       snz_done;
    logic       beep_ph;
    logic       ringing;
    logic       snoozing;
    logic       buzz;
    logic [2:0] snooze_cnt;

    assign match = (bus.t_hh == bus.a_hh) && (bus.t_hl == bus.a_hl) &&
                   (bus.t_mh == bus.a_mh) && (bus.t_ml == bus.a_ml) &&
                   (bus.t_sh == bus.a_sh) && (bus.t_sl == bus.a_sl);
    assign match_rise = match & ~match_q;

    // Event priority: disarm/dismiss beat snooze, and a taken snooze swallows the same-cycle tick.
    assign abort       = ~bus.alarm_en | bus.dismiss;
    assign take_snooze = (state == ST_RING) & ~abort & bus.snooze & (snooze_cnt < 3'(MAX_SNOOZE));
    assign ring_tick   = (state == ST_RING) & ~abort & ~take_snooze & bus.sec_tick;
    assign snz_tick    = (state == ST_SNOOZE) & ~abort & bus.sec_tick;

    alarm_sec_timer #(.N(RING_SECS)) u_ring_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_RING),
        .tick  (ring_tick),
        .done  (ring_done)
    );

    alarm_sec_timer #(.N(SNOOZE_SECS)) u_snooze_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_SNOOZE),
        .tick  (snz_tick),
        .done  (snz_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            match_q    <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzz       <= 1'b0;
            beep_ph    <= 1'b0;
            snooze_cnt <= '0;
        end else begin
            match_q <= match;
            case (state)
                ST_IDLE: begin
                    if (bus.alarm_en && match_rise) begin
                        state      <= ST_RING;
                        ringing    <= 1'b1;
                        buzz       <= 1'b1;
                        beep_ph    <= 1'b1;
                        snooze_cnt <= '0;
                    end
                end
                ST_RING: begin
                    if (abort || ring_done) begin
                        state      <= ST_IDLE;
                        ringing    <= 1'b0;
                        buzz       <= 1'b0;
                        snooze_cnt <= '0;
                    end else if (take_snooze) begin
                        state      <= ST_SNOOZE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                        buzz       <= 1'b0;
                        snooze_cnt <= snooze_cnt + 3'd1;
                    end else if (ring_tick) begin
                        beep_ph <= ~beep_ph;
                        buzz    <= BEEP ? ~beep_ph : 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        snoozing   <= 1'b0;
                        snooze_cnt <= '0;
                    end else if (snz_done) begin
                        state    <= ST_RING;
                        snoozing <= 1'b0;
                        ringing  <= 1'b1;
                        buzz     <= 1'b1;
                        beep_ph  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ringing    <= 1'b0;
                    snoozing   <= 1'b0;
                    buzz       <= 1'b0;
                    snooze_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ringing    = ringing;
    assign bus.snoozing   = snoozing;
    assign bus.buzz       = buzz;
    assign bus.snooze_cnt = snooze_cnt;

endmodule

// File: tb/tb_alarm_trigger_fsm.sv
// Self-checking bench for alarm_trigger_fsm: a behavioural model pushes the
// expected outputs each cycle; they are popped and compared after the clock edge.
module tb_alarm_trigger_fsm;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;
`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    typedef struct packed {
        logic       ring;
        logic       snz;
        logic       buzz;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alarm_trigger_fsm_if bus ();

    alarm_trigger_fsm #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int now_s;
    int alarm_s;
    int m_st, m_rt, m_zt, m_cnt;
    bit m_mq, m_beep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int s);
        bus.t_hh = 4'((s / 3600) / 10);
        bus.t_hl = 4'((s / 3600) % 10);
        bus.t_mh = 4'(((s % 3600) / 60) / 10);
        bus.t_ml = 4'(((s % 3600) / 60) % 10);
        bus.t_sh = 4'((s % 60) / 10);
        bus.t_sl = 4'((s % 60) % 10);
    endtask

    task automatic set_alarm(input int s);
        bus.a_hh = 4'((s / 3600) / 10);
        bus.a_hl = 4'((s / 3600) % 10);
        bus.a_mh = 4'(((s % 3600) / 60) / 10);
        bus.a_ml = 4'(((s % 3600) / 60) % 10);
        bus.a_sh = 4'((s % 60) / 10);
        bus.a_sl = 4'((s % 60) % 10);
    endtask

    // Reference behaviour evaluated on the inputs presented for the coming edge.
    task automatic model_step();
        bit   mt;
        bit   rise;
        exp_t e;
        if (reset) begin
            m_st = 0; m_rt = 0; m_zt = 0; m_cnt = 0; m_mq = 0; m_beep = 0;
        end else begin
            mt   = (now_s == alarm_s);
            rise = mt && !m_mq;
            m_mq = mt;
            case (m_st)
                0: if (bus.alarm_en && rise) begin
                    m_st = 1; m_rt = 0; m_cnt = 0; m_beep = 1;
                end
                1: if (!bus.alarm_en || bus.dismiss) begin
                    m_st = 0; m_cnt = 0;
                end else if (bus.snooze && m_cnt < MAX_SNOOZE) begin
                    m_st = 2; m_zt = 0; m_cnt++;
                end else if (bus.sec_tick) begin
                    if (m_rt == RING_SECS - 1) begin
                        m_st = 0; m_cnt = 0;
                    end else begin
                        m_rt++; m_beep = !m_beep;
                    end
                end
                default: if (!bus.alarm_en || bus.dismiss) begin
                    m_st = 0; m_cnt = 0;
                end else if (bus.sec_tick) begin
                    if (m_zt == SNOOZE_SECS - 1) begin
                        m_st = 1; m_rt = 0; m_beep = 1;
                    end else begin
                        m_zt++;
                    end
                end
            endcase
        end
        e.ring = (m_st == 1);
        e.snz  = (m_st == 2);
        e.buzz = (m_st == 1) && (BEEP ? m_beep : 1'b1);
        e.cnt  = 3'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check("ringing",    32'(bus.ringing),    32'(e.ring));
            check("snoozing",   32'(bus.snoozing),   32'(e.snz));
            check("buzz",       32'(bus.buzz),       32'(e.buzz));
            check("snooze_cnt", 32'(bus.snooze_cnt), 32'(e.cnt));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            now_s++;
            set_time(now_s);
            bus.sec_tick = 1'b1;
            cycle();
            bus.sec_tick = 1'b0;
            cycle();
            cycle();
        end
    endtask

    task automatic press_snooze();
        bus.snooze = 1'b1;
        cycle();
        bus.snooze = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.sec_tick = 1'b0;
        bus.alarm_en = 1'b0;
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        now_s   = 7 * 3600 + 29 * 60 + 50;
        alarm_s = 7 * 3600 + 30 * 60;
        set_time(now_s);
        set_alarm(alarm_s);
        @(posedge clk); #1;
        cycle();
        cycle();
        check("rst_ringing",  32'(bus.ringing),    0);
        check("rst_buzz",     32'(bus.buzz),       0);
        check("rst_snoozing", 32'(bus.snoozing),   0);
        check("rst_cnt",      32'(bus.snooze_cnt), 0);
        reset = 1'b0;
        bus.alarm_en = 1'b1;
        cycle();

        // Alarm fires one clock after the tick reaching 07:30:00
        tick(9);
        check("t1_pre_ring", 32'(bus.ringing), 0);
        now_s++;
        set_time(now_s);
        bus.sec_tick = 1'b1;
        cycle();
        bus.sec_tick = 1'b0;
        check("t1_ringing", 32'(bus.ringing), 1);
        check("t1_buzz",    32'(bus.buzz),    1);
        cycle();

        // Beep pattern across ticks, then timeout after the 60th tick
        tick(1);
        check("t6_beep_1", 32'(bus.buzz), BEEP ? 0 : 1);
        tick(1);
        check("t6_beep_2", 32'(bus.buzz), 1);
        tick(57);
        check("t2_still_ringing", 32'(bus.ringing), 1);
        tick(1);
        check("t2_timeout", 32'(bus.ringing), 0);
        tick(5);
        check("t2_no_retrigger", 32'(bus.ringing), 0);

        // Snooze coinciding with a tick, then resume after 300 s
        alarm_s = now_s + 2;
        set_alarm(alarm_s);
        tick(2);
        check("t3_ring", 32'(bus.ringing), 1);
        now_s++;
        set_time(now_s);
        bus.sec_tick = 1'b1;
        bus.snooze   = 1'b1;
        cycle();
        bus.sec_tick = 1'b0;
        bus.snooze   = 1'b0;
        check("t3_snoozing", 32'(bus.snoozing),   1);
        check("t3_cnt1",     32'(bus.snooze_cnt), 1);
        check("t3_quiet",    32'(bus.buzz),       0);
        cycle();
        tick(SNOOZE_SECS - 1);
        check("t3_still_snoozing", 32'(bus.snoozing), 1);
        tick(1);
        check("t3_resume", 32'(bus.ringing), 1);

        // Snooze limit, then dismiss
        press_snooze();
        tick(SNOOZE_SECS);
        check("t4_cnt2", 32'(bus.snooze_cnt), 2);
        press_snooze();
        tick(SNOOZE_SECS);
        check("t4_ring3", 32'(bus.ringing),    1);
        check("t4_cnt3",  32'(bus.snooze_cnt), 3);
        press_snooze();
        check("t4_max_ringing",  32'(bus.ringing),    1);
        check("t4_max_snoozing", 32'(bus.snoozing),   0);
        check("t4_max_cnt",      32'(bus.snooze_cnt), 3);
        bus.dismiss = 1'b1;
        cycle();
        bus.dismiss = 1'b0;
        check("t4_dismiss_ring", 32'(bus.ringing),    0);
        check("t4_dismiss_cnt",  32'(bus.snooze_cnt), 0);

        // Match while disarmed, arm in the same second: no ring
        bus.alarm_en = 1'b0;
        alarm_s = now_s + 2;
        set_alarm(alarm_s);
        tick(2);
        bus.alarm_en = 1'b1;
        cycle();
        cycle();
        check("t5_no_latent", 32'(bus.ringing), 0);

        // Disarm mid-snooze
        alarm_s = now_s + 2;
        set_alarm(alarm_s);
        tick(2);
        press_snooze();
        check("t5_snoozing", 32'(bus.snoozing), 1);
        bus.alarm_en = 1'b0;
        cycle();
        check("t5_disarm", 32'(bus.snoozing), 0);
        bus.alarm_en = 1'b1;
        cycle();

        // Reset mid-ringing with a snooze already used
        alarm_s = now_s + 2;
        set_alarm(alarm_s);
        tick(2);
        press_snooze();
        tick(SNOOZE_SECS);
        check("t6_ring_pre_rst", 32'(bus.ringing), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_rst_ringing",  32'(bus.ringing),    0);
        check("t6_rst_buzz",     32'(bus.buzz),       0);
        check("t6_rst_snoozing", 32'(bus.snoozing),   0);
        check("t6_rst_cnt",      32'(bus.snooze_cnt), 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
